// File: rtl/rsa_pkg.sv
// Shared types and default widths for the RSA modular-exponentiation controller.
package rsa_pkg;
    localparam int unsigned BITLEN_DEF = 1024;
    localparam int unsigned EXPLEN_DEF = 1024;
    localparam int unsigned IDXW_DEF   = 11;
    localparam int unsigned CNTW       = 10;

    typedef enum logic [2:0] {ST_DRAIN, ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;
    typedef enum logic [2:0] {OP_CONV_X, OP_CONV_1, OP_SQR, OP_MUL, OP_CONV_OUT} op_e;
endpackage

// File: rtl/mod_exp_opsel.sv
// Operation sequencing for square-and-multiply: next-op decode after a capture,
// and the operand mux for the op about to be issued.
module mod_exp_opsel
    import rsa_pkg::*;
#(
    parameter int unsigned BITLEN = BITLEN_DEF,
    parameter int unsigned EXPLEN = EXPLEN_DEF,
    parameter int unsigned IDXW   = IDXW_DEF
) (
    input  op_e               cur_op,
    input  logic [IDXW-1:0]   idx,
    input  logic [EXPLEN-1:0] exp_val,
    output op_e               next_op_c,
    output logic              dec_idx_c,
    output logic              last_c,
    input  op_e               issue_op,
    input  logic [BITLEN-1:0] base_val,
    input  logic [BITLEN-1:0] r2_val,
    input  logic [BITLEN-1:0] acc_val,
    input  logic [BITLEN-1:0] xbar_val,
    output logic [BITLEN-1:0] mp_a_c,
    output logic [BITLEN-1:0] mp_b_c
);
    logic [EXPLEN-1:0] exp_shift;
    logic              bit_set;
    logic              more_bits;

    // idx counts remaining bits, so the current bit is exponent[idx-1]
    assign exp_shift = exp_val >> (idx - IDXW'(1));
    assign bit_set   = exp_shift[0];
    assign more_bits = (idx > IDXW'(1));

    always_comb begin
        next_op_c = OP_CONV_X;
        dec_idx_c = 1'b0;
        last_c    = 1'b0;
        case (cur_op)
            OP_CONV_X: next_op_c = OP_CONV_1;
            OP_CONV_1: next_op_c = (idx != '0) ? OP_SQR : OP_CONV_OUT;
            OP_SQR: begin
                if (bit_set) begin
                    next_op_c = OP_MUL;
                end else begin
                    dec_idx_c = 1'b1;
                    next_op_c = more_bits ? OP_SQR : OP_CONV_OUT;
                end
            end
            OP_MUL: begin
                dec_idx_c = 1'b1;
                next_op_c = more_bits ? OP_SQR : OP_CONV_OUT;
            end
            OP_CONV_OUT: last_c = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        mp_a_c = '0;
        mp_b_c = '0;
        case (issue_op)
            OP_CONV_X:   begin mp_a_c = base_val;       mp_b_c = r2_val;         end
            OP_CONV_1:   begin mp_a_c = BITLEN'(1);     mp_b_c = r2_val;         end
            OP_SQR:      begin mp_a_c = acc_val;        mp_b_c = acc_val;        end
            OP_MUL:      begin mp_a_c = acc_val;        mp_b_c = xbar_val;       end
            OP_CONV_OUT: begin mp_a_c = acc_val;        mp_b_c = BITLEN'(1);     end
            default: ;
        endcase
    end
endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller driving an external Montgomery
// multiplier; owns its start/stop handshake and operand registers.
module mod_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int unsigned BITLEN = BITLEN_DEF,
    parameter int unsigned EXPLEN = EXPLEN_DEF,
    parameter int unsigned IDXW   = IDXW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BITLEN-1:0] base,
    input  logic [EXPLEN-1:0] exponent,
    input  logic [IDXW-1:0]   exp_bits,
    input  logic [BITLEN-1:0] modulus,
    input  logic [BITLEN-1:0] r2,
    input  logic [CNTW-1:0]   mp_len,
    output logic              busy,
    output logic              done,
    output logic [BITLEN-1:0] result,
    output logic              mp_start,
    output logic [BITLEN-1:0] mp_a,
    output logic [BITLEN-1:0] mp_b,
    output logic [BITLEN-1:0] mp_m,
    output logic [CNTW-1:0]   mp_count,
    input  logic              mp_stop,
    input  logic [BITLEN:0]   mp_p
);
    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              first_q, first_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mp_start_q, mp_start_d;
    logic [BITLEN-1:0] base_q, base_d, r2_q, r2_d, mod_q, mod_d;
    logic [EXPLEN-1:0] exp_q, exp_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [BITLEN-1:0] acc_q, acc_d, xbar_q, xbar_d, result_q, result_d;
    logic [BITLEN-1:0] mp_a_q, mp_a_d, mp_b_q, mp_b_d;

    op_e               next_op;
    logic              dec_idx, last_op;
    logic [BITLEN-1:0] sel_a, sel_b;
    logic              accept, capture;
    logic              unused_p_msb;

    assign accept       = (state_q == ST_IDLE) && start;
    assign capture      = (state_q == ST_WAIT) && !first_q && mp_stop;
    assign unused_p_msb = mp_p[BITLEN];

    mod_exp_opsel #(.BITLEN(BITLEN), .EXPLEN(EXPLEN), .IDXW(IDXW)) u_opsel (
        .cur_op    (op_q),
        .idx       (idx_q),
        .exp_val   (exp_q),
        .next_op_c (next_op),
        .dec_idx_c (dec_idx),
        .last_c    (last_op),
        .issue_op  (op_d),
        .base_val  (base_d),
        .r2_val    (r2_d),
        .acc_val   (acc_d),
        .xbar_val  (xbar_d),
        .mp_a_c    (sel_a),
        .mp_b_c    (sel_b)
    );

    // Operand capture on start and product write-back on multiplier completion
    always_comb begin
        base_d   = base_q;
        r2_d     = r2_q;
        mod_d    = mod_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        xbar_d   = xbar_q;
        result_d = result_q;
        if (accept) begin
            base_d = base;
            r2_d   = r2;
            mod_d  = modulus;
            exp_d  = exponent;
            cnt_d  = mp_len;
        end
        if (capture) begin
            case (op_q)
                OP_CONV_X:   xbar_d   = mp_p[BITLEN-1:0];
                OP_CONV_OUT: result_d = mp_p[BITLEN-1:0];
                default:     acc_d    = mp_p[BITLEN-1:0];
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mp_start_d = 1'b0;
        first_d    = 1'b0;
        case (state_q)
            ST_DRAIN: begin
                busy_d = 1'b0;
                if (mp_stop) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ISSUE;
                    op_d       = OP_CONV_X;
                    idx_d      = exp_bits;
                    busy_d     = 1'b1;
                    mp_start_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                first_d = 1'b1;
            end
            ST_WAIT: begin
                // mp_stop may still show the previous idle state in the first WAIT cycle
                if (capture) begin
                    if (last_op) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = ST_ISSUE;
                        op_d       = next_op;
                        mp_start_d = 1'b1;
                        if (dec_idx) idx_d = idx_q - IDXW'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_DRAIN;
        endcase
    end

    // Operands change only when a new op is issued, then hold through WAIT
    always_comb begin
        mp_a_d = mp_start_d ? sel_a : mp_a_q;
        mp_b_d = mp_start_d ? sel_b : mp_b_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_DRAIN;
            op_q       <= OP_CONV_X;
            idx_q      <= '0;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mp_start_q <= 1'b0;
            base_q     <= '0;
            r2_q       <= '0;
            mod_q      <= '0;
            exp_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            xbar_q     <= '0;
            result_q   <= '0;
            mp_a_q     <= '0;
            mp_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            first_q    <= first_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mp_start_q <= mp_start_d;
            base_q     <= base_d;
            r2_q       <= r2_d;
            mod_q      <= mod_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            xbar_q     <= xbar_d;
            result_q   <= result_d;
            mp_a_q     <= mp_a_d;
            mp_b_q     <= mp_b_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign mp_start = mp_start_q;
    assign mp_a     = mp_a_q;
    assign mp_b     = mp_b_q;
    assign mp_m     = mod_q;
    assign mp_count = cnt_q;
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural Montgomery multiplier (M=13, R=16, T_mp=7)
// and a plain modular-power reference model.
module tb_mod_exp_ctrl;
    localparam int unsigned BL = 8;
    localparam int unsigned EL = 8;
    localparam int unsigned IW = 4;
    localparam int M    = 13;
    localparam int R    = 16;
    localparam int R2   = 9;
    localparam int TMP  = 7;
    localparam int BOUND = 3000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [BL-1:0] base = '0;
    logic [EL-1:0] exponent = '0;
    logic [IW-1:0] exp_bits = '0;
    logic [BL-1:0] modulus = 8'(M);
    logic [BL-1:0] r2 = 8'(R2);
    logic [9:0]    mp_len = 10'd4;
    logic          busy, done, mp_start, mp_stop;
    logic [BL-1:0] result, mp_a, mp_b, mp_m;
    logic [9:0]    mp_count;
    logic [BL:0]   mp_p = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_start = 0;
    int n_done = 0;
    int mdl_cnt = 0;
    int stall_until = 0;

    logic [BL-1:0] r_res, r_first_a, r_first_b;
    int r_starts, r_dones, r_unstable, r_busy_at_done;
    bit r_tmo;

    mod_exp_ctrl #(.BITLEN(BL), .EXPLEN(EL), .IDXW(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .exponent(exponent),
        .exp_bits(exp_bits), .modulus(modulus), .r2(r2), .mp_len(mp_len),
        .busy(busy), .done(done), .result(result), .mp_start(mp_start),
        .mp_a(mp_a), .mp_b(mp_b), .mp_m(mp_m), .mp_count(mp_count),
        .mp_stop(mp_stop), .mp_p(mp_p)
    );

    always #5 clk = ~clk;

    function automatic int find_rinv();
        for (int x = 1; x < M; x++) if ((R * x) % M == 1) return x;
        return 0;
    endfunction

    // Multiplier model: no reset; busy for TMP-1 cycles after the start edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mp_start === 1'b1) n_start <= n_start + 1;
        if (done === 1'b1) n_done <= n_done + 1;
        if (mp_start === 1'b1) begin
            mdl_cnt <= TMP - 1;
            mp_p    <= 9'((int'(mp_a) * int'(mp_b) * find_rinv()) % M);
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
        end
    end
    assign mp_stop = (mdl_cnt == 0) && (cyc >= stall_until);

    function automatic int ref_pow(int b, int e, int nb);
        int r  = 1 % M;
        int sq = b % M;
        for (int i = 0; i < nb; i++) begin
            if (((e >> i) & 1) == 1) r = (r * sq) % M;
            sq = (sq * sq) % M;
        end
        return r;
    endfunction

    function automatic int ref_ops(int e, int nb);
        logic [31:0] masked;
        masked = 32'(e & ((1 << nb) - 1));
        return 3 + nb + $countones(masked);
    endfunction

    task automatic run_exp(input int b, input int e, input int nb, input bit hammer);
        int s0, d0;
        logic [BL-1:0] a_seen, b_seen;
        bit first;
        s0 = n_start; d0 = n_done;
        a_seen = '0; b_seen = '0; first = 1'b1;
        r_unstable = 0; r_busy_at_done = 0; r_tmo = 1'b1;
        r_first_a = '0; r_first_b = '0;
        @(negedge clk);
        base = 8'(b); exponent = 8'(e); exp_bits = 4'(nb); start = 1'b1;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (!hammer) start = 1'b0;
            if (mp_start) begin
                a_seen = mp_a; b_seen = mp_b;
                if (first) begin r_first_a = mp_a; r_first_b = mp_b; first = 1'b0; end
            end else if (busy && (mp_a !== a_seen || mp_b !== b_seen)) begin
                r_unstable++;
            end
            if (done) begin
                r_tmo = 1'b0;
                r_busy_at_done = int'(busy);
                break;
            end
        end
        start = 1'b0;
        r_res = result;
        @(negedge clk);
        r_starts = n_start - s0;
        r_dones  = n_done - d0;
    endtask

    task automatic test_reset;
        @(negedge clk); @(negedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %0d want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %0d want 0", done); end
        checks++; if (mp_start !== 1'b0) begin errors++; $display("FAIL reset_mp_start got %0d want 0", mp_start); end
        checks++; if (result !== '0)     begin errors++; $display("FAIL reset_result got %0d want 0", result); end
        checks++; if (mp_a !== '0 || mp_b !== '0) begin errors++; $display("FAIL reset_mp_ab got %0d/%0d want 0/0", mp_a, mp_b); end
        checks++; if (mp_m !== '0)       begin errors++; $display("FAIL reset_mp_m got %0d want 0", mp_m); end
        checks++; if (mp_count !== '0)   begin errors++; $display("FAIL reset_mp_count got %0d want 0", mp_count); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_vectors;
        int tb_base [5] = '{7, 4, 0, 12, 2};
        int tb_exp  [5] = '{5, 0, 3, 2, 255};
        int tb_bits [5] = '{3, 0, 2, 2, 2};
        int tb_res  [5] = '{11, 1, 0, 1, 8};
        int tb_ops  [5] = '{8, 3, 7, 6, 7};
        for (int v = 0; v < 5; v++) begin
            run_exp(tb_base[v], tb_exp[v], tb_bits[v], 1'b0);
            checks++; if (r_tmo) begin errors++; $display("FAIL vec%0d_timeout got no done want done", v); end
            checks++; if (r_res !== 8'(tb_res[v])) begin errors++; $display("FAIL vec%0d_result got %0d want %0d", v, r_res, tb_res[v]); end
            checks++; if (r_starts != tb_ops[v]) begin errors++; $display("FAIL vec%0d_mp_starts got %0d want %0d", v, r_starts, tb_ops[v]); end
            checks++; if (r_dones != 1) begin errors++; $display("FAIL vec%0d_done_pulses got %0d want 1", v, r_dones); end
            checks++; if (r_busy_at_done != 0) begin errors++; $display("FAIL vec%0d_busy_at_done got %0d want 0", v, r_busy_at_done); end
            checks++; if (r_first_a !== 8'(tb_base[v]) || r_first_b !== 8'(R2)) begin
                errors++; $display("FAIL vec%0d_first_operands got %0d/%0d want %0d/%0d", v, r_first_a, r_first_b, tb_base[v], R2);
            end
            checks++; if (r_unstable != 0) begin errors++; $display("FAIL vec%0d_operand_hold got %0d changes want 0", v, r_unstable); end
        end
        checks++; if (mp_m !== 8'(M) || mp_count !== 10'd4) begin
            errors++; $display("FAIL mp_m_count got %0d/%0d want %0d/4", mp_m, mp_count, M);
        end
    endtask

    task automatic test_random;
        int b, e, nb, exp_res, exp_ops;
        for (int n = 0; n < 12; n++) begin
            b  = int'($urandom_range(0, M - 1));
            e  = int'($urandom_range(0, 255));
            nb = int'($urandom_range(0, EL));
            exp_res = ref_pow(b, e, nb);
            exp_ops = ref_ops(e, nb);
            run_exp(b, e, nb, 1'b0);
            checks++; if (r_tmo || r_res !== 8'(exp_res)) begin
                errors++; $display("FAIL rand%0d_result b=%0d e=%0d nb=%0d got %0d want %0d tmo=%0d", n, b, e, nb, r_res, exp_res, r_tmo);
            end
            checks++; if (r_starts != exp_ops) begin
                errors++; $display("FAIL rand%0d_mp_starts got %0d want %0d", n, r_starts, exp_ops);
            end
        end
    endtask

    task automatic test_back_to_back;
        run_exp(7, 5, 3, 1'b1);
        checks++; if (r_tmo || r_res !== 8'd11) begin errors++; $display("FAIL b2b_result got %0d want 11 tmo=%0d", r_res, r_tmo); end
        checks++; if (r_starts != 8) begin errors++; $display("FAIL b2b_mp_starts got %0d want 8", r_starts); end
        checks++; if (r_dones != 1) begin errors++; $display("FAIL b2b_done_pulses got %0d want 1", r_dones); end
        checks++; if (r_unstable != 0) begin errors++; $display("FAIL b2b_operand_hold got %0d changes want 0", r_unstable); end
    endtask

    task automatic test_reset_mid;
        int s0, bad_busy;
        bit seen_stop;
        @(negedge clk);
        base = 8'd7; exponent = 8'd5; exp_bits = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before_rst got %0d want 1", busy); end
        rst = 1'b1;
        stall_until = cyc + 22;
        #1;
        checks++; if (busy !== 1'b0 || mp_start !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_rst_outputs got busy=%0d start=%0d done=%0d want 0/0/0", busy, mp_start, done);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        s0 = n_start; bad_busy = 0;
        for (int i = 0; i < 16; i++) begin
            start = 1'b1;
            @(negedge clk);
            if (busy !== 1'b0) bad_busy++;
        end
        start = 1'b0;
        seen_stop = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mp_stop) begin seen_stop = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen_stop) begin errors++; $display("FAIL drain_stop_timeout got 0 want 1"); end
        checks++; if (n_start != s0) begin errors++; $display("FAIL drain_mp_starts got %0d want 0", n_start - s0); end
        checks++; if (bad_busy != 0) begin errors++; $display("FAIL drain_busy got %0d cycles high want 0", bad_busy); end
        repeat (2) @(negedge clk);
        run_exp(7, 5, 3, 1'b0);
        checks++; if (r_tmo || r_res !== 8'd11) begin errors++; $display("FAIL post_rst_result got %0d want 11 tmo=%0d", r_res, r_tmo); end
        checks++; if (r_starts != 8) begin errors++; $display("FAIL post_rst_mp_starts got %0d want 8", r_starts); end
    endtask

    initial begin
        #2 rst = 1'b1;
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
